// File: rtl/parafuzz_barrier_ctrl_if.sv
// Signal bundle between the lockstep barrier controller and the dual-core harness.
// The master modport is the harness side (commit streams in, holds/status back).
interface parafuzz_barrier_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             en;
    logic             dut_valid;
    logic [31:0]      dut_inst;
    logic             vnt_valid;
    logic [31:0]      vnt_inst;
    logic             hold_dut;
    logic             hold_vnt;
    logic             sync_pulse;
    logic [3:0]       sync_code;
    logic [2:0]       cur_phase;
    logic             in_phase;
    logic [CNT_W-1:0] barrier_cnt;
    logic             err;
    logic [1:0]       err_code;

    modport master (
        output en, dut_valid, dut_inst, vnt_valid, vnt_inst,
        input  hold_dut, hold_vnt, sync_pulse, sync_code, cur_phase,
               in_phase, barrier_cnt, err, err_code
    );

    modport slave (
        input  en, dut_valid, dut_inst, vnt_valid, vnt_inst,
        output hold_dut, hold_vnt, sync_pulse, sync_code, cur_phase,
               in_phase, barrier_cnt, err, err_code
    );
endinterface

// File: rtl/parafuzz_barrier_ctrl.sv
// Lockstep barrier controller: parks whichever core commits a phase marker first
// until the other core commits the same marker, then releases both together.
module parafuzz_barrier_ctrl #(
    parameter int TIMEOUT = 4096,
    parameter int CNT_W   = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    parafuzz_barrier_ctrl_if.slave bus
);

    localparam int WCNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_DUT,
        WAIT_VNT,
        ERROR
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'd0,
        ERR_MISMATCH = 2'd1,
        ERR_TIMEOUT  = 2'd2,
        ERR_HELD     = 2'd3
    } err_t;

    // A marker is the fixed low pattern with a 12-bit immediate in 0..13.
    function automatic logic is_marker(input logic [31:0] inst);
        return (inst[19:0] == 20'h02013) && (inst[31:20] <= 12'd13);
    endfunction

    function automatic logic [3:0] marker_code(input logic [31:0] inst);
        return inst[23:20];
    endfunction

    function automatic logic [WCNT_W-1:0] sat_inc(input logic [WCNT_W-1:0] v);
        return (v == {WCNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    state_t           r_state;
    state_t           w_state_nxt;
    logic [3:0]       r_code;
    logic [WCNT_W-1:0] r_wait_cnt;

    logic             r_hold_dut;
    logic             r_hold_vnt;
    logic             r_sync_pulse;
    logic [3:0]       r_sync_code;
    logic [2:0]       r_cur_phase;
    logic             r_in_phase;
    logic [CNT_W-1:0] r_barrier_cnt;
    logic             r_err;
    logic [1:0]       r_err_code;

    logic             w_dut_mk;
    logic             w_vnt_mk;
    logic [3:0]       w_dut_code;
    logic [3:0]       w_vnt_code;
    logic             w_timeout;
    logic             w_pass;
    logic [3:0]       w_pass_code;
    logic             w_latch;
    logic [3:0]       w_latch_code;
    logic             w_err_set;
    err_t             w_err_cause;

    assign w_dut_mk   = bus.dut_valid && is_marker(bus.dut_inst);
    assign w_vnt_mk   = bus.vnt_valid && is_marker(bus.vnt_inst);
    assign w_dut_code = marker_code(bus.dut_inst);
    assign w_vnt_code = marker_code(bus.vnt_inst);
    assign w_timeout  = (r_wait_cnt == WCNT_W'(TIMEOUT - 1));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Within a wait cycle: held-side commit beats a code mismatch, which beats a
    // timeout; a correct closing marker on the last wait cycle still passes.
    always_comb begin
        w_state_nxt  = r_state;
        w_pass       = 1'b0;
        w_pass_code  = r_code;
        w_latch      = 1'b0;
        w_latch_code = w_dut_code;
        w_err_set    = 1'b0;
        w_err_cause  = ERR_NONE;

        case (r_state)
            IDLE: begin
                if (bus.en) begin
                    if (w_dut_mk && w_vnt_mk) begin
                        if (w_dut_code == w_vnt_code) begin
                            w_pass      = 1'b1;
                            w_pass_code = w_dut_code;
                        end else begin
                            w_err_set   = 1'b1;
                            w_err_cause = ERR_MISMATCH;
                        end
                    end else if (w_dut_mk) begin
                        w_latch      = 1'b1;
                        w_latch_code = w_dut_code;
                        w_state_nxt  = WAIT_VNT;
                    end else if (w_vnt_mk) begin
                        w_latch      = 1'b1;
                        w_latch_code = w_vnt_code;
                        w_state_nxt  = WAIT_DUT;
                    end
                end
            end

            WAIT_VNT: begin
                if (!bus.en) begin
                    w_state_nxt = IDLE;
                end else if (bus.dut_valid && r_hold_dut) begin
                    w_err_set   = 1'b1;
                    w_err_cause = ERR_HELD;
                end else if (w_vnt_mk && (w_vnt_code != r_code)) begin
                    w_err_set   = 1'b1;
                    w_err_cause = ERR_MISMATCH;
                end else if (w_vnt_mk) begin
                    w_pass      = 1'b1;
                    w_state_nxt = IDLE;
                end else if (w_timeout) begin
                    w_err_set   = 1'b1;
                    w_err_cause = ERR_TIMEOUT;
                end
            end

            WAIT_DUT: begin
                if (!bus.en) begin
                    w_state_nxt = IDLE;
                end else if (bus.vnt_valid && r_hold_vnt) begin
                    w_err_set   = 1'b1;
                    w_err_cause = ERR_HELD;
                end else if (w_dut_mk && (w_dut_code != r_code)) begin
                    w_err_set   = 1'b1;
                    w_err_cause = ERR_MISMATCH;
                end else if (w_dut_mk) begin
                    w_pass      = 1'b1;
                    w_state_nxt = IDLE;
                end else if (w_timeout) begin
                    w_err_set   = 1'b1;
                    w_err_cause = ERR_TIMEOUT;
                end
            end

            ERROR: begin
                w_state_nxt = ERROR;
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        if (w_err_set) begin
            w_state_nxt = ERROR;
        end
    end

    // Latched marker code and wait counter; the counter restarts on every entry.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_code     <= 4'd0;
            r_wait_cnt <= '0;
        end else begin
            if (w_latch) begin
                r_code <= w_latch_code;
            end
            if ((r_state == WAIT_VNT || r_state == WAIT_DUT) && (w_state_nxt == r_state)) begin
                r_wait_cnt <= sat_inc(r_wait_cnt);
            end else begin
                r_wait_cnt <= '0;
            end
        end
    end

    // Holds mirror the next state so they rise on the edge that parks a core.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_hold_dut    <= 1'b0;
            r_hold_vnt    <= 1'b0;
            r_sync_pulse  <= 1'b0;
            r_sync_code   <= 4'd0;
            r_cur_phase   <= 3'd0;
            r_in_phase    <= 1'b0;
            r_barrier_cnt <= '0;
            r_err         <= 1'b0;
            r_err_code    <= 2'd0;
        end else begin
            r_hold_dut   <= (w_state_nxt == WAIT_VNT);
            r_hold_vnt   <= (w_state_nxt == WAIT_DUT);
            r_sync_pulse <= w_pass;
            if (w_pass) begin
                r_sync_code   <= w_pass_code;
                r_cur_phase   <= w_pass_code[3:1];
                r_in_phase    <= ~w_pass_code[0];
                r_barrier_cnt <= r_barrier_cnt + 1'b1;
            end
            r_err <= (w_state_nxt == ERROR);
            if (w_err_set) begin
                r_err_code <= w_err_cause;
            end
        end
    end

    assign bus.hold_dut    = r_hold_dut;
    assign bus.hold_vnt    = r_hold_vnt;
    assign bus.sync_pulse  = r_sync_pulse;
    assign bus.sync_code   = r_sync_code;
    assign bus.cur_phase   = r_cur_phase;
    assign bus.in_phase    = r_in_phase;
    assign bus.barrier_cnt = r_barrier_cnt;
    assign bus.err         = r_err;
    assign bus.err_code    = r_err_code;

endmodule

// File: tb/tb_parafuzz_barrier_ctrl.sv
// Directed bench for the lockstep barrier controller (TIMEOUT=8, CNT_W=2).
module tb_parafuzz_barrier_ctrl;

    localparam logic [31:0] NOP = 32'h00000013;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   errors = 0;
    int   checks = 0;
    int   nhold;

    always #5 clock = ~clock;

    parafuzz_barrier_ctrl_if #(.CNT_W(2)) bus ();

    parafuzz_barrier_ctrl #(.TIMEOUT(8), .CNT_W(2)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic commit(input logic dv, input logic [31:0] di,
                          input logic vv, input logic [31:0] vi);
        bus.dut_valid = dv;
        bus.dut_inst  = di;
        bus.vnt_valid = vv;
        bus.vnt_inst  = vi;
        tick();
        bus.dut_valid = 1'b0;
        bus.vnt_valid = 1'b0;
        bus.dut_inst  = NOP;
        bus.vnt_inst  = NOP;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #2;
        @(negedge clock);
        reset = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.en        = 1'b1;
        bus.dut_valid = 1'b0;
        bus.vnt_valid = 1'b0;
        bus.dut_inst  = NOP;
        bus.vnt_inst  = NOP;

        // Reset values, applied asynchronously.
        #2 reset = 1'b0;
        #1;
        chk("rst_hold_dut", 32'(bus.hold_dut), 0);
        chk("rst_hold_vnt", 32'(bus.hold_vnt), 0);
        chk("rst_pulse", 32'(bus.sync_pulse), 0);
        chk("rst_code", 32'(bus.sync_code), 0);
        chk("rst_phase", 32'(bus.cur_phase), 0);
        chk("rst_in_phase", 32'(bus.in_phase), 0);
        chk("rst_cnt", 32'(bus.barrier_cnt), 0);
        chk("rst_err", 32'(bus.err), 0);
        chk("rst_err_code", 32'(bus.err_code), 0);
        @(negedge clock);
        reset = 1'b1;

        // Simultaneous barrier.
        commit(1'b1, 32'h00402013, 1'b1, 32'h00402013);
        chk("sim_pulse", 32'(bus.sync_pulse), 1);
        chk("sim_code", 32'(bus.sync_code), 4);
        chk("sim_phase", 32'(bus.cur_phase), 2);
        chk("sim_in_phase", 32'(bus.in_phase), 1);
        chk("sim_hold_dut", 32'(bus.hold_dut), 0);
        chk("sim_hold_vnt", 32'(bus.hold_vnt), 0);
        chk("sim_cnt", 32'(bus.barrier_cnt), 1);
        tick();
        chk("sim_pulse_off", 32'(bus.sync_pulse), 0);
        chk("sim_code_kept", 32'(bus.sync_code), 4);

        // Immediate 14 is not a marker; 13 is the highest valid one.
        commit(1'b1, 32'h00e02013, 1'b1, 32'h00e02013);
        chk("imm14_pulse", 32'(bus.sync_pulse), 0);
        chk("imm14_cnt", 32'(bus.barrier_cnt), 1);
        commit(1'b1, 32'h00d02013, 1'b1, 32'h00d02013);
        chk("imm13_pulse", 32'(bus.sync_pulse), 1);
        chk("imm13_code", 32'(bus.sync_code), 13);
        chk("imm13_phase", 32'(bus.cur_phase), 6);
        chk("imm13_in_phase", 32'(bus.in_phase), 0);
        chk("imm13_cnt", 32'(bus.barrier_cnt), 2);

        // DUT leads by six cycles.
        do_reset();
        nhold = 0;
        commit(1'b1, 32'h00002013, 1'b0, NOP);
        chk("lead_hold_vnt", 32'(bus.hold_vnt), 0);
        if (bus.hold_dut) nhold++;
        for (int i = 0; i < 5; i++) begin
            commit(1'b0, NOP, 1'b1, NOP);
            chk("lead_hold_dut", 32'(bus.hold_dut), 1);
            if (bus.hold_dut) nhold++;
        end
        commit(1'b0, NOP, 1'b1, 32'h00002013);
        chk("lead_released", 32'(bus.hold_dut), 0);
        chk("lead_pulse", 32'(bus.sync_pulse), 1);
        chk("lead_cnt", 32'(bus.barrier_cnt), 1);
        chk("lead_code", 32'(bus.sync_code), 0);
        chk("lead_in_phase", 32'(bus.in_phase), 1);
        chk("lead_hold_cycles", 32'(nhold), 6);

        // Variant leads with an END marker.
        commit(1'b0, NOP, 1'b1, 32'h00302013);
        chk("vlead_hold_vnt", 32'(bus.hold_vnt), 1);
        chk("vlead_hold_dut", 32'(bus.hold_dut), 0);
        commit(1'b1, NOP, 1'b0, NOP);
        chk("vlead_wait", 32'(bus.hold_vnt), 1);
        chk("vlead_no_err", 32'(bus.err), 0);
        commit(1'b1, 32'h00302013, 1'b0, NOP);
        chk("vlead_released", 32'(bus.hold_vnt), 0);
        chk("vlead_pulse", 32'(bus.sync_pulse), 1);
        chk("vlead_code", 32'(bus.sync_code), 3);
        chk("vlead_phase", 32'(bus.cur_phase), 1);
        chk("vlead_in_phase", 32'(bus.in_phase), 0);
        chk("vlead_cnt", 32'(bus.barrier_cnt), 2);
        commit(1'b0, NOP, 1'b1, NOP);
        chk("vlead_free_commit", 32'(bus.err), 0);

        // Marker mismatch while parked; error is sticky.
        do_reset();
        commit(1'b1, 32'h00002013, 1'b0, NOP);
        chk("mm_hold", 32'(bus.hold_dut), 1);
        commit(1'b0, NOP, 1'b1, 32'h00102013);
        chk("mm_err", 32'(bus.err), 1);
        chk("mm_code", 32'(bus.err_code), 1);
        chk("mm_hold_dut", 32'(bus.hold_dut), 0);
        chk("mm_hold_vnt", 32'(bus.hold_vnt), 0);
        bus.en = 1'b0;
        tick();
        bus.en = 1'b1;
        chk("mm_sticky_en", 32'(bus.err), 1);
        commit(1'b1, 32'h00402013, 1'b1, 32'h00402013);
        chk("mm_no_pass", 32'(bus.sync_pulse), 0);
        chk("mm_code_kept", 32'(bus.err_code), 1);
        chk("mm_cnt", 32'(bus.barrier_cnt), 0);

        // Mismatch committed in the same cycle from IDLE.
        do_reset();
        commit(1'b1, 32'h00402013, 1'b1, 32'h00502013);
        chk("imm_err", 32'(bus.err), 1);
        chk("imm_code", 32'(bus.err_code), 1);
        chk("imm_pulse", 32'(bus.sync_pulse), 0);

        // Timeout: error exactly 8 cycles after hold rises.
        do_reset();
        commit(1'b1, 32'h00002013, 1'b0, NOP);
        chk("to_hold", 32'(bus.hold_dut), 1);
        for (int i = 0; i < 7; i++) begin
            commit(1'b0, NOP, 1'b1, NOP);
            chk("to_wait_no_err", 32'(bus.err), 0);
        end
        commit(1'b0, NOP, 1'b1, NOP);
        chk("to_err", 32'(bus.err), 1);
        chk("to_code", 32'(bus.err_code), 2);
        chk("to_hold_clr", 32'(bus.hold_dut), 0);

        // Mismatch outranks timeout on the final wait cycle.
        do_reset();
        commit(1'b1, 32'h00002013, 1'b0, NOP);
        for (int i = 0; i < 7; i++) commit(1'b0, NOP, 1'b0, NOP);
        commit(1'b0, NOP, 1'b1, 32'h00102013);
        chk("prio12_code", 32'(bus.err_code), 1);

        // Commit while held.
        do_reset();
        commit(1'b1, 32'h00002013, 1'b0, NOP);
        commit(1'b1, NOP, 1'b0, NOP);
        chk("held_err", 32'(bus.err), 1);
        chk("held_code", 32'(bus.err_code), 3);
        chk("held_hold", 32'(bus.hold_dut), 0);

        // Held commit outranks a simultaneous mismatch.
        do_reset();
        commit(1'b0, NOP, 1'b1, 32'h00202013);
        chk("prio31_hold", 32'(bus.hold_vnt), 1);
        commit(1'b1, 32'h00402013, 1'b1, NOP);
        chk("prio31_code", 32'(bus.err_code), 3);

        // Disable while parked returns to IDLE.
        do_reset();
        commit(1'b0, NOP, 1'b1, 32'h00202013);
        chk("dis_hold", 32'(bus.hold_vnt), 1);
        bus.en = 1'b0;
        tick();
        chk("dis_hold_clr", 32'(bus.hold_vnt), 0);
        chk("dis_no_err", 32'(bus.err), 0);
        bus.en = 1'b1;
        commit(1'b1, 32'h00202013, 1'b0, NOP);
        chk("dis_idle_park", 32'(bus.hold_dut), 1);
        chk("dis_idle_nopass", 32'(bus.sync_pulse), 0);

        // Asynchronous reset while parked, between clock edges.
        reset = 1'b0;
        #2;
        chk("arst_hold", 32'(bus.hold_dut), 0);
        @(negedge clock);
        reset = 1'b1;

        // Barrier counter wraps at CNT_W=2.
        for (int i = 1; i <= 4; i++) begin
            commit(1'b1, 32'h00602013, 1'b1, 32'h00602013);
            chk("wrap_cnt", 32'(bus.barrier_cnt), 32'(i % 4));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
